// File: rtl/gpr_file_sb.sv
// Parametrised GPR file with per-register busy scoreboard and a one-register-per-cycle clear engine.
// Optional write-first forwarding from the writeback port is enabled by defining GPR_BYPASS_EN.
module gpr_file_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_req,
    output logic            ready,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   cnt_next;
    logic            clearing;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;

    logic            wb_en;
    logic            iss_en;

    // Addresses at or above NREG only exist when NREG is not a power of two.
    function automatic logic in_range(input logic [AW-1:0] a);
        return (32'(a) < 32'(NREG));
    endfunction

    // State register: reset always restarts the clear sweep from register 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_CLEAR: begin
                if (cnt == LAST_IDX) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (clr_req) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        ready    = 1'b0;
        clearing = 1'b0;
        case (state)
            ST_CLEAR: clearing = 1'b1;
            ST_RUN:   ready    = 1'b1;
            default:  clearing = 1'b1;
        endcase
    end

    // Writes to x0 or to nonexistent registers are dropped, as is everything while clearing.
    assign wb_en  = ready && wb_valid  && (wb_rd  != '0) && in_range(wb_rd);
    assign iss_en = ready && iss_valid && (iss_rd != '0) && in_range(iss_rd);

    always_ff @(posedge clk) begin
        if (clearing) begin
            regs[cnt] <= '0;
        end else if (wb_en) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Issue takes priority over writeback: a newer producer is in flight for that register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (clearing && (32'(cnt) == i)) begin
                busy[i] <= 1'b0;
            end else if (iss_en && (32'(iss_rd) == i)) begin
                busy[i] <= 1'b1;
            end else if (wb_en && (32'(wb_rd) == i)) begin
                busy[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        rs1_data = '0;
        rs1_busy = 1'b0;
        if (ready && (rs1_addr != '0) && in_range(rs1_addr)) begin
            rs1_data = regs[rs1_addr];
            rs1_busy = busy[rs1_addr];
`ifdef GPR_BYPASS_EN
            if (wb_valid && (wb_rd == rs1_addr)) begin
                rs1_data = wb_data;
                rs1_busy = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        rs2_data = '0;
        rs2_busy = 1'b0;
        if (ready && (rs2_addr != '0) && in_range(rs2_addr)) begin
            rs2_data = regs[rs2_addr];
            rs2_busy = busy[rs2_addr];
`ifdef GPR_BYPASS_EN
            if (wb_valid && (wb_rd == rs2_addr)) begin
                rs2_data = wb_data;
                rs2_busy = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_gpr_file_sb.sv
// Directed bench for gpr_file_sb: a 32x32 instance plus a 24x64 instance for out-of-range addresses.
module tb_gpr_file_sb;

    logic        clk = 1'b0;
    logic        rst;

    logic        clr_req, ready;
    logic [4:0]  rs1_addr, rs2_addr, iss_rd, wb_rd;
    logic [31:0] rs1_data, rs2_data, wb_data;
    logic        rs1_busy, rs2_busy, iss_valid, wb_valid;

    logic        clr_req_b, ready_b;
    logic [4:0]  rs1_addr_b, rs2_addr_b, iss_rd_b, wb_rd_b;
    logic [63:0] rs1_data_b, rs2_data_b, wb_data_b;
    logic        rs1_busy_b, rs2_busy_b, iss_valid_b, wb_valid_b;

    int n_assert = 0;
    int n_fail   = 0;
    int na, nb, n;

    always #5 clk = ~clk;

    gpr_file_sb #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    gpr_file_sb #(.XLEN(64), .NREG(24)) dut_b (
        .clk(clk), .rst(rst), .clr_req(clr_req_b), .ready(ready_b),
        .rs1_addr(rs1_addr_b), .rs2_addr(rs2_addr_b),
        .rs1_data(rs1_data_b), .rs2_data(rs2_data_b),
        .rs1_busy(rs1_busy_b), .rs2_busy(rs2_busy_b),
        .iss_valid(iss_valid_b), .iss_rd(iss_rd_b),
        .wb_valid(wb_valid_b), .wb_rd(wb_rd_b), .wb_data(wb_data_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr_req     = 1'b0;
        iss_valid   = 1'b0;
        wb_valid    = 1'b0;
        clr_req_b   = 1'b0;
        iss_valid_b = 1'b0;
        wb_valid_b  = 1'b0;
    endtask

    // Edge index (1-based) at which each instance first shows ready; -1 if the bound expires.
    task automatic wait_ready(output int ka, output int kb);
        ka = -1;
        kb = -1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (ready && ka < 0) ka = k;
            if (ready_b && kb < 0) kb = k;
            if (ka >= 0 && kb >= 0) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle();
        rs1_addr = 5'd5; rs2_addr = 5'd0; iss_rd = '0; wb_rd = '0; wb_data = '0;
        rs1_addr_b = '0; rs2_addr_b = '0; iss_rd_b = '0; wb_rd_b = '0; wb_data_b = '0;

        // Reset and initial clear
        tick();
        tick();
        check("reset_ready", ready, 0);
        check("reset_rs1_data", rs1_data, 0);
        check("reset_rs1_busy", rs1_busy, 0);
        rst = 1'b0;
        #1;
        check("post_reset_ready", ready, 0);
        wait_ready(na, nb);
        check("clear_len_32", na, 32);
        check("clear_len_24", nb, 24);

        for (int a = 1; a < 32; a += 6) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            #1;
            check("cleared_rs1_data", rs1_data, 0);
            check("cleared_rs1_busy", rs1_busy, 0);
            check("cleared_rs2_data", rs2_data, 0);
            check("cleared_rs2_busy", rs2_busy, 0);
        end

        // Scoreboard: issue rd=5, writeback three cycles later
        rs1_addr = 5'd5;
        iss_valid = 1'b1; iss_rd = 5'd5;
        #1;
        check("sb_before_issue_busy", rs1_busy, 0);
        tick();
        idle();
        #1;
        check("sb_busy_c1", rs1_busy, 1);
        tick();
        check("sb_busy_c2", rs1_busy, 1);
        tick();
        check("sb_busy_c3", rs1_busy, 1);
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        #1;
`ifdef GPR_BYPASS_EN
        check("sb_wb_cycle_data", rs1_data, 32'hDEADBEEF);
        check("sb_wb_cycle_busy", rs1_busy, 0);
`else
        check("sb_wb_cycle_data", rs1_data, 0);
        check("sb_wb_cycle_busy", rs1_busy, 1);
`endif
        tick();
        idle();
        #1;
        check("sb_after_wb_data", rs1_data, 32'hDEADBEEF);
        check("sb_after_wb_busy", rs1_busy, 0);

        // Simultaneous issue and writeback on rd=7
        rs1_addr = 5'd7;
        iss_valid = 1'b1; iss_rd = 5'd7;
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h12345678;
        #1;
`ifdef GPR_BYPASS_EN
        check("sim7_same_data", rs1_data, 32'h12345678);
`else
        check("sim7_same_data", rs1_data, 0);
`endif
        check("sim7_same_busy", rs1_busy, 0);
        tick();
        idle();
        #1;
        check("sim7_next_data", rs1_data, 32'h12345678);
        check("sim7_next_busy", rs1_busy, 1);

        // x0 protection
        rs2_addr = 5'd0;
        iss_valid = 1'b1; iss_rd = 5'd0;
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        #1;
        check("x0_same_data", rs2_data, 0);
        check("x0_same_busy", rs2_busy, 0);
        tick();
        idle();
        #1;
        check("x0_next_data", rs2_data, 0);
        check("x0_next_busy", rs2_busy, 0);

        // Clear mid-run
        rs1_addr = 5'd9; rs2_addr = 5'd3;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'hA5A5A5A5;
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        idle();
        #1;
        check("pre_clr_r9", rs1_data, 32'hA5A5A5A5);
        check("pre_clr_busy3", rs2_busy, 1);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        #1;
        check("clr_ready_drop", ready, 0);
        check("clr_read_zero", rs1_data, 0);
        check("clr_busy_zero", rs2_busy, 0);
        wb_valid = 1'b1; wb_rd = 5'd12; wb_data = 32'h55555555;
        iss_valid = 1'b1; iss_rd = 5'd14;
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        idle();
        check("clr_len", n, 32);
        rs1_addr = 5'd9; rs2_addr = 5'd3;
        #1;
        check("post_clr_r9", rs1_data, 0);
        check("post_clr_busy3", rs2_busy, 0);
        rs1_addr = 5'd12; rs2_addr = 5'd14;
        #1;
        check("clr_dropped_wb12", rs1_data, 0);
        check("clr_dropped_iss14", rs2_busy, 0);

        // Async reset in the middle of a clear
        wb_valid = 1'b1; wb_rd = 5'd20; wb_data = 32'hCAFEF00D;
        tick();
        idle();
        rs1_addr = 5'd20;
        #1;
        check("r20_written", rs1_data, 32'hCAFEF00D);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        check("mid_clear_ready", ready, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ready", ready, 0);
        tick();
        rst = 1'b0;
        wait_ready(na, nb);
        check("rst_restart_len_32", na, 32);
        check("rst_restart_len_24", nb, 24);
        #1;
        check("r20_cleared", rs1_data, 0);

        // 24x64 instance: out-of-range addresses
        wb_valid_b = 1'b1; wb_rd_b = 5'd23; wb_data_b = 64'h0123_4567_89AB_CDEF;
        iss_valid_b = 1'b1; iss_rd_b = 5'd30;
        tick();
        wb_rd_b = 5'd30; wb_data_b = 64'hFFFF_FFFF_FFFF_FFFF;
        iss_rd_b = 5'd22;
        tick();
        idle();
        rs1_addr_b = 5'd30; rs2_addr_b = 5'd23;
        #1;
        check("b_r30_data", rs1_data_b, 0);
        check("b_r30_busy", rs1_busy_b, 0);
        check("b_r23_data", rs2_data_b, 64'h0123_4567_89AB_CDEF);
        check("b_r23_busy", rs2_busy_b, 0);
        rs1_addr_b = 5'd22;
        #1;
        check("b_r22_busy", rs1_busy_b, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
